// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_pkg
// Description : Shared definitions for the 2x2 switch ingress port:
//               destination tags, ingress FSM state encoding and the
//               FIFO entry layout {da, eop, data}.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_pkg;

   // Destination tags understood by the 2x2 switch
   localparam logic [3:0] DA_PORT_A = 4'b0001;
   localparam logic [3:0] DA_PORT_B = 4'b0010;
   localparam logic [3:0] DA_NONE   = 4'b0000;

   // Data width of the default build; the top re-derives the same layout
   // for other DW values.
   localparam int unsigned ENTRY_DW = 32;

   // Ingress packet FSM
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_DROP    = 2'd2
   } ingress_state_t;

   // One buffered word as stored in the ingress FIFO
   typedef struct packed {
      logic [3:0]          da;
      logic                eop;
      logic [ENTRY_DW-1:0] data;
   } fifo_entry_t;

   // True for tags that address one of the two switch outputs
   function automatic logic da_is_routable(input logic [3:0] da);
      return (da == DA_PORT_A) || (da == DA_PORT_B);
   endfunction

endpackage
`default_nettype wire

// File: rtl/switch_ingress_fifo.sv
`default_nettype none
// ============================================================================
// Module      : switch_ingress_fifo
// Description : Synchronous FIFO, DEPTH entries of WIDTH bits. Pointers
//               carry one extra wrap bit so full and empty are distinct.
//               Push while full and pop while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_ingress_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 37
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   // Pointer update; pointers wrap naturally modulo 2*DEPTH
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage write; contents need no reset since empty masks them
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/switch_ingress_port.sv
`default_nettype none
// ============================================================================
// Module      : switch_ingress_port
// Description : Ingress port of a 2x2 switch. Parses packets (sop/eop),
//               keeps packets whose header DA addresses port A or B,
//               tags every word with that DA, buffers them in a FIFO and
//               presents them registered to the switch. Other packets are
//               discarded.
//               Optional macro SWITCH_INGRESS_DROP_CNT_EN adds drop_cnt,
//               a saturating count of discarded headers.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_ingress_port
   import switch_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          resetN,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   input  logic          in_sop,
   input  logic          in_eop,
   output logic          in_ready,
   input  logic          out_en,
   output logic [DW-1:0] dout,
   output logic [3:0]    DA_out,
`ifdef SWITCH_INGRESS_DROP_CNT_EN
   output logic [15:0]   drop_cnt,
`endif
   output logic          dout_eop
);

   // Same field order as switch_pkg::fifo_entry_t, sized by DW
   typedef struct packed {
      logic [3:0]    da;
      logic          eop;
      logic [DW-1:0] data;
   } entry_t;

   ingress_state_t state;
   ingress_state_t state_nx;
   logic [3:0]     pkt_da;
   logic [3:0]     pkt_da_nx;
   logic           accept;
   logic           push;
   logic           pop;
   logic           full;
   logic           empty;
   logic           hdr_drop;
   entry_t         wentry;
   entry_t         rentry;
   logic [$bits(entry_t)-1:0] fifo_rdata;

   // A dropped packet is always drained; otherwise backpressure on full
   assign in_ready = (state == ST_DROP) || !full;
   assign accept   = in_valid && in_ready;
   assign pop      = out_en && !empty;
   assign rentry   = fifo_rdata;

   // FSM state and latched packet destination
   always_ff @(posedge clk) begin
      if (resetN) begin
         state  <= ST_IDLE;
         pkt_da <= DA_NONE;
      end else begin
         state  <= state_nx;
         pkt_da <= pkt_da_nx;
      end
   end

   // Packet parsing: header classification, payload tagging, FIFO write
   always_comb begin
      state_nx  = state;
      pkt_da_nx = pkt_da;
      push      = 1'b0;
      hdr_drop  = 1'b0;
      wentry    = '{da: pkt_da, eop: in_eop, data: in_data};
      if (accept) begin
         if (in_sop) begin
            // A new header closes whatever packet was in progress
            if (da_is_routable(in_data[3:0])) begin
               push      = 1'b1;
               wentry.da = in_data[3:0];
               pkt_da_nx = in_data[3:0];
               // Only reachable from DROP: a header that finds the FIFO
               // full cannot be stored, so its packet is discarded
               if (in_eop)    state_nx = ST_IDLE;
               else if (full) state_nx = ST_DROP;
               else           state_nx = ST_PAYLOAD;
            end else begin
               hdr_drop = 1'b1;
               state_nx = in_eop ? ST_IDLE : ST_DROP;
            end
         end else begin
            case (state)
               ST_PAYLOAD: begin
                  push = 1'b1;
                  if (in_eop) state_nx = ST_IDLE;
               end
               ST_DROP: begin
                  if (in_eop) state_nx = ST_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   switch_ingress_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (resetN),
      .push  (push),
      .pop   (pop),
      .wdata (wentry),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty)
   );

   // Output register: the popped entry, or an idle word with no destination
   always_ff @(posedge clk) begin
      if (resetN) begin
         dout     <= '0;
         DA_out   <= DA_NONE;
         dout_eop <= 1'b0;
      end else if (pop) begin
         dout     <= rentry.data;
         DA_out   <= rentry.da;
         dout_eop <= rentry.eop;
      end else begin
         dout     <= '0;
         DA_out   <= DA_NONE;
         dout_eop <= 1'b0;
      end
   end

`ifdef SWITCH_INGRESS_DROP_CNT_EN
   // Saturating count of discarded headers
   always_ff @(posedge clk) begin
      if (resetN) begin
         drop_cnt <= '0;
      end else if (hdr_drop && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_ingress_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_ingress_port
// Description : Self-checking bench for switch_ingress_port: directed
//               packet scenarios followed by random traffic, all compared
//               against a queue-based packet model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_ingress_port;

   localparam int DEPTH = 8;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          resetN;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_sop;
   logic          in_eop;
   logic          in_ready;
   logic          out_en;
   logic [DW-1:0] dout;
   logic [3:0]    DA_out;
   logic          dout_eop;
`ifdef SWITCH_INGRESS_DROP_CNT_EN
   logic [15:0]   drop_cnt;
`endif

   switch_ingress_port #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk      (clk),
      .resetN   (resetN),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_sop   (in_sop),
      .in_eop   (in_eop),
      .in_ready (in_ready),
      .out_en   (out_en),
      .dout     (dout),
      .DA_out   (DA_out),
`ifdef SWITCH_INGRESS_DROP_CNT_EN
      .drop_cnt (drop_cnt),
`endif
      .dout_eop (dout_eop)
   );

   always #5 clk = ~clk;

   // Reference model: queue of words the switch should still receive, and
   // the fate of the packet currently arriving.
   typedef struct {
      logic [3:0]    da;
      logic          eop;
      logic [DW-1:0] data;
   } exp_t;

   exp_t q[$];
   int   pkt_fate;   // 0: between packets, 1: kept packet, 2: discarded packet
   logic [3:0] pkt_dest;
   int   drops;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      pkt_fate = 0;
      pkt_dest = 4'd0;
      drops    = 0;
   endtask

   // One clock cycle with the given inputs; returns whether the word was taken
   task automatic cycle(input logic v, input logic sop, input logic eop,
                        input logic [DW-1:0] d, input logic oen, output logic acc);
      exp_t e;
      int   sz0;
      logic m_ready;
      logic [DW-1:0] ed;
      logic [3:0]    eda;
      logic          eeop;
      in_valid = v; in_sop = sop; in_eop = eop; in_data = d; out_en = oen;
      sz0     = q.size();
      m_ready = (pkt_fate == 2) || (sz0 < DEPTH);
      chk("in_ready", {63'd0, in_ready}, {63'd0, m_ready});
      acc = v && m_ready;
      ed = '0; eda = 4'd0; eeop = 1'b0;
      if (oen && sz0 > 0) begin
         e = q.pop_front();
         ed = e.data; eda = e.da; eeop = e.eop;
      end
      if (acc) begin
         if (sop) begin
            if (d[3:0] == 4'd1 || d[3:0] == 4'd2) begin
               if (sz0 < DEPTH) begin
                  q.push_back('{da: d[3:0], eop: eop, data: d});
                  pkt_fate = eop ? 0 : 1;
               end else begin
                  pkt_fate = eop ? 0 : 2;
               end
               pkt_dest = d[3:0];
            end else begin
               if (drops < 16'hFFFF) drops++;
               pkt_fate = eop ? 0 : 2;
            end
         end else if (pkt_fate == 1) begin
            q.push_back('{da: pkt_dest, eop: eop, data: d});
            if (eop) pkt_fate = 0;
         end else if (pkt_fate == 2 && eop) begin
            pkt_fate = 0;
         end
      end
      @(posedge clk);
      #1;
      chk("dout", {32'd0, dout}, {32'd0, ed});
      chk("DA_out", {60'd0, DA_out}, {60'd0, eda});
      chk("dout_eop", {63'd0, dout_eop}, {63'd0, eeop});
`ifdef SWITCH_INGRESS_DROP_CNT_EN
      chk("drop_cnt", {48'd0, drop_cnt}, 64'(drops));
`endif
   endtask

   // Offer one word until accepted, within a cycle budget
   task automatic send(input logic sop, input logic eop, input logic [DW-1:0] d, input logic oen);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 64 && !acc; i++) cycle(1'b1, sop, eop, d, oen, acc);
      chk("send_accepted", {63'd0, acc}, 64'd1);
   endtask

   task automatic idle(input int n, input logic oen);
      logic acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, oen, acc);
   endtask

   task automatic do_reset();
      resetN = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      in_data = '0; out_en = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      resetN = 1'b0;
      chk("rst_dout", {32'd0, dout}, 64'd0);
      chk("rst_DA_out", {60'd0, DA_out}, 64'd0);
      chk("rst_dout_eop", {63'd0, dout_eop}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef SWITCH_INGRESS_DROP_CNT_EN
      chk("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
`endif
   endtask

   initial begin
      logic acc;
      logic [DW-1:0] w;
      logic [3:0] da_pick [4];
      da_pick[0] = 4'd1; da_pick[1] = 4'd2; da_pick[2] = 4'd7; da_pick[3] = 4'd0;
      model_reset();

      do_reset();
      do_reset();

      // Basic two-word packet to port A
      send(1'b1, 1'b0, 32'hA5A5_0001, 1'b1);
      send(1'b0, 1'b1, 32'h1111_1111, 1'b1);
      idle(3, 1'b1);

      // Unroutable header with payload is discarded
      send(1'b1, 1'b0, 32'h0000_0007, 1'b1);
      send(1'b0, 1'b0, 32'h2222_2222, 1'b1);
      send(1'b0, 1'b0, 32'h3333_3333, 1'b1);
      send(1'b0, 1'b1, 32'h4444_4444, 1'b1);
      idle(2, 1'b1);

      // Non-sop words between packets are ignored
      send(1'b0, 1'b0, 32'h5555_0001, 1'b1);
      idle(2, 1'b1);

      // Backpressure: fill with out_en=0, then drain
      send(1'b1, 1'b0, 32'hB000_0002, 1'b0);
      for (int i = 1; i < 8; i++) send(1'b0, 1'b0, 32'hB000_0000 + 32'(i << 4), 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 32'hB000_0080, 1'b0, acc);
      send(1'b0, 1'b0, 32'hB000_0080, 1'b1);
      send(1'b0, 1'b1, 32'hB000_0090, 1'b1);
      idle(12, 1'b1);

      // New header in the middle of a packet
      send(1'b1, 1'b0, 32'hC000_0002, 1'b1);
      send(1'b0, 1'b0, 32'hC000_0010, 1'b1);
      send(1'b1, 1'b0, 32'hD000_0001, 1'b1);
      send(1'b0, 1'b1, 32'hD000_0010, 1'b1);
      idle(3, 1'b1);

      // Reset with a partially buffered packet
      send(1'b1, 1'b0, 32'hE000_0002, 1'b0);
      send(1'b0, 1'b0, 32'hE000_0010, 1'b0);
      send(1'b0, 1'b0, 32'hE000_0020, 1'b0);
      send(1'b0, 1'b0, 32'hE000_0030, 1'b0);
      do_reset();
      send(1'b0, 1'b0, 32'hE000_0040, 1'b1);
      send(1'b0, 1'b1, 32'hE000_0050, 1'b1);
      idle(3, 1'b1);

      // Back-to-back single-word packets
      send(1'b1, 1'b1, 32'hF000_0001, 1'b1);
      send(1'b1, 1'b1, 32'hF100_0001, 1'b1);
      send(1'b1, 1'b1, 32'hF200_0001, 1'b1);
      idle(3, 1'b1);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic v, s, e, o;
         v = ($urandom_range(0, 9) < 8);
         s = ($urandom_range(0, 9) < 3);
         e = ($urandom_range(0, 9) < 3);
         o = ($urandom_range(0, 9) < 6);
         w = $urandom;
         if (s) w[3:0] = da_pick[$urandom_range(0, 3)];
         cycle(v, s, e, w, o, acc);
      end
      idle(DEPTH + 2, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
